// File: rtl/wb_sel.sv
// Write-back source select: picks ALU result, load value or PC+4 and registers it.
// Optional WBSEL_LOAD_EXT_EN formats byte/halfword loads with sign/zero extension.
module wb_sel #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] alu,
  input  logic [XLEN-1:0] data_mem,
  input  logic [XLEN-1:0] PC,
  input  logic [1:0]      WBSel_pin,
  input  logic [2:0]      mem_funct3,
  input  logic [1:0]      mem_addr_lo,
  output logic [XLEN-1:0] WBsel_op,
  output logic [XLEN-1:0] WBsel_op_q
);

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_LOAD = 2'b01,
    SEL_PC4  = 2'b10,
    SEL_RSVD = 2'b11
  } wb_src_e;

  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] pc_plus4;

  assign pc_plus4 = PC + XLEN'(4);

`ifdef WBSEL_LOAD_EXT_EN
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Misaligned halfwords still pick the half addressed by bit 1.
  assign half_val = mem_addr_lo[1] ? data_mem[31:16] : data_mem[15:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    byte_val = data_mem[7:0];
    case (mem_addr_lo)
      2'b01:   byte_val = data_mem[15:8];
      2'b10:   byte_val = data_mem[23:16];
      2'b11:   byte_val = data_mem[31:24];
      default: byte_val = data_mem[7:0];
    endcase
  end

  always_comb begin
    load_val = data_mem;
    case (mem_funct3)
      F3_LB:   load_val = {{(XLEN-8){byte_val[7]}}, byte_val};
      F3_LH:   load_val = {{(XLEN-16){half_val[15]}}, half_val};
      F3_LBU:  load_val = {{(XLEN-8){1'b0}}, byte_val};
      F3_LHU:  load_val = {{(XLEN-16){1'b0}}, half_val};
      default: load_val = data_mem;
    endcase
  end
`else
  logic unused_load_fmt;

  assign unused_load_fmt = ^{mem_funct3, mem_addr_lo};
  assign load_val        = data_mem;
`endif

  always_comb begin
    WBsel_op = '0;
    case (WBSel_pin)
      SEL_ALU:  WBsel_op = alu;
      SEL_LOAD: WBsel_op = load_val;
      SEL_PC4:  WBsel_op = pc_plus4;
      SEL_RSVD: WBsel_op = '0;
      default:  WBsel_op = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments to avoid simulation races.
    if (rst) WBsel_op_q <= '0;
    else     WBsel_op_q <= WBsel_op;
  end

endmodule

// File: tb/tb_wb_sel.sv
// Directed self-checking bench for wb_sel; expectations follow WBSEL_LOAD_EXT_EN when defined.
module tb_wb_sel;

  logic        clk;
  logic        rst;
  logic [31:0] alu;
  logic [31:0] data_mem;
  logic [31:0] PC;
  logic [1:0]  WBSel_pin;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr_lo;
  logic [31:0] WBsel_op;
  logic [31:0] WBsel_op_q;

  int checks = 0;
  int errors = 0;

  wb_sel #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu        (alu),
    .data_mem   (data_mem),
    .PC         (PC),
    .WBSel_pin  (WBSel_pin),
    .mem_funct3 (mem_funct3),
    .mem_addr_lo(mem_addr_lo),
    .WBsel_op   (WBsel_op),
    .WBsel_op_q (WBsel_op_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // Load-format vector: funct3, addr_lo, data, expected with and without extension.
  typedef struct {
    string       tag;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] data;
    logic [31:0] exp_ext;
  } load_vec_t;

  load_vec_t lv[8];

  initial begin
    lv[0] = '{"lb_a1",     3'b000, 2'b01, 32'h0000_80FF, 32'hFFFF_FF80};
    lv[1] = '{"lbu_a1",    3'b100, 2'b01, 32'h0000_80FF, 32'h0000_0080};
    lv[2] = '{"lh_a2",     3'b001, 2'b10, 32'h8001_7FFF, 32'hFFFF_8001};
    lv[3] = '{"lhu_a0",    3'b101, 2'b00, 32'h8001_7FFF, 32'h0000_7FFF};
    lv[4] = '{"lh_mis_a3", 3'b001, 2'b11, 32'h8001_7FFF, 32'hFFFF_8001};
    lv[5] = '{"lb_a0",     3'b000, 2'b00, 32'h8001_7FFF, 32'hFFFF_FFFF};
    lv[6] = '{"lbu_a3",    3'b100, 2'b11, 32'h8001_7FFF, 32'h0000_0080};
    lv[7] = '{"undef_f3",  3'b011, 2'b01, 32'h8001_7FFF, 32'h8001_7FFF};

    rst = 1'b1; alu = '0; data_mem = '0; PC = '0;
    WBSel_pin = 2'b00; mem_funct3 = 3'b010; mem_addr_lo = 2'b00;
    edge_step();
    check("reset_q", WBsel_op_q, 32'h0);

    // Release reset: q must update only on the following edge.
    rst = 1'b0; alu = 32'h0000_5555; WBSel_pin = 2'b00;
    #1;
    check("q_before_edge", WBsel_op_q, 32'h0);
    edge_step();
    check("q_after_edge", WBsel_op_q, 32'h0000_5555);

    // Basic selects with word load.
    data_mem = 32'h0000_1111; PC = 32'h0000_1A0A; mem_funct3 = 3'b010;
    WBSel_pin = 2'b00; #1 check("sel_alu",  WBsel_op, 32'h0000_5555);
    WBSel_pin = 2'b01; #1 check("sel_load", WBsel_op, 32'h0000_1111);
    WBSel_pin = 2'b10; #1 check("sel_pc4",  WBsel_op, 32'h0000_1A0E);
    WBSel_pin = 2'b11; #1 check("sel_rsvd", WBsel_op, 32'h0);

    PC = 32'hFFFF_FFFC; WBSel_pin = 2'b10;
    #1 check("pc4_wrap", WBsel_op, 32'h0);

    // Load formatting inputs must not leak into non-load selects.
    WBSel_pin = 2'b00; mem_funct3 = 3'b000; mem_addr_lo = 2'b11;
    #1 check("alu_f3_ignored", WBsel_op, 32'h0000_5555);
    WBSel_pin = 2'b10; PC = 32'h0000_0100; mem_funct3 = 3'b101;
    #1 check("pc_f3_ignored", WBsel_op, 32'h0000_0104);

    WBSel_pin = 2'b01;
    foreach (lv[i]) begin
      mem_funct3 = lv[i].f3; mem_addr_lo = lv[i].lo; data_mem = lv[i].data;
      #1;
`ifdef WBSEL_LOAD_EXT_EN
      check(lv[i].tag, WBsel_op, lv[i].exp_ext);
`else
      check(lv[i].tag, WBsel_op, lv[i].data);
`endif
    end

    // Select toggle between edges: combinational path moves, register holds.
    @(negedge clk);
    WBSel_pin = 2'b00; alu = 32'h0000_5555; mem_funct3 = 3'b010; data_mem = 32'h0000_1111;
    edge_step();
    check("q_hold_alu", WBsel_op_q, 32'h0000_5555);
    WBSel_pin = 2'b01;
    #1;
    check("toggle_comb", WBsel_op, 32'h0000_1111);
    check("toggle_q_hold", WBsel_op_q, 32'h0000_5555);
    edge_step();
    check("toggle_q_upd", WBsel_op_q, 32'h0000_1111);

    // Reset mid-operation overrides capture; combinational output unaffected.
    WBSel_pin = 2'b00; alu = 32'h1234_5678; rst = 1'b1;
    #1 check("comb_in_rst", WBsel_op, 32'h1234_5678);
    edge_step();
    check("q_mid_rst", WBsel_op_q, 32'h0);
    rst = 1'b0;
    edge_step();
    check("q_after_rst", WBsel_op_q, 32'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
